pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline sequencer for the five-stage LA32R core (IF, ID, EX, MEM, WB). It issues per-stage hold and flush controls to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and redirects the PC. It resolves three conditions: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-RAM accesses completed by a req/ack handshake. It also provides a watchdog on RAM waits and a stall-cycle performance counter.

## Interface

Parameters:
- `WAIT_LIMIT`, default 255: maximum number of consecutive MEM wait cycles before the error trap.

Ports:
- `cpu_clk` in 1: core clock; all state updates on its rising edge.
- `cpu_rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: ID holds a valid instruction.
- `id_re1` in 1: ID instruction reads `id_rR1`.
- `id_re2` in 1: ID instruction reads `id_rR2`.
- `id_rR1` in 5: first source register index.
- `id_rR2` in 5: second source register index.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_rf_we` in 1: EX instruction writes the register file.
- `ex_is_load` in 1: EX write data comes from RAM.
- `ex_wR` in 5: EX destination register.
- `ex_br_taken` in 1: EX resolved a taken branch or jump.
- `ex_br_target` in 32: redirect address.
- `mem_req` in 1: MEM stage has a valid RAM access this cycle.
- `mem_ack` in 1: RAM data/write completes this cycle.
- `pc_hold` out 1: PC keeps its value.
- `ifid_hold` out 1: IF/ID register holds.
- `ifid_flush` out 1: IF/ID register loads a bubble (valid=0).
- `idex_hold` out 1: ID/EX register holds.
- `idex_flush` out 1: ID/EX register loads a bubble.
- `exmem_hold` out 1: EX/MEM register holds.
- `memwb_flush` out 1: MEM/WB register loads a bubble.
- `redirect` out 1: PC loads `redirect_pc` next edge.
- `redirect_pc` out 32: equals `ex_br_target`.
- `wait_err` out 1: sticky watchdog error.
- `stall_cnt` out 32: count of cycles with `pc_hold`=1.

## Operation

- FSM states: RUN, WAIT, ERR. Reset value: RUN, `wait_cnt`=0, `stall_cnt`=0, `wait_err`=0.
- Control outputs are combinational from state and inputs. While `cpu_rst`=1 they are all 0, except that `ifid_flush`, `idex_flush` and `memwb_flush` are 1.
- Load-use condition `lu`: `ex_valid & ex_rf_we & ex_is_load & ex_wR!=0 & id_valid & ((id_re1 & id_rR1==ex_wR) | (id_re2 & id_rR2==ex_wR))`.
- Memory-wait condition `mw`: `mem_req & !mem_ack`.
- Priority, highest first:
  - ERR
  - WAIT/`mw`
  - `ex_br_taken`
  - `lu`
- `mw` (in RUN or WAIT):
  - `pc_hold`, `ifid_hold`, `idex_hold` and `exmem_hold` are 1; `memwb_flush`=1.
  - `redirect`=0 and `lu` is ignored.
- `ex_br_taken` with no `mw`:
  - `redirect`=1, `ifid_flush`=1, `idex_flush`=1.
  - No holds; `lu` is ignored because the ID instruction is squashed.
- `lu` alone:
  - `pc_hold`=1, `ifid_hold`=1, `idex_flush`=1 (one bubble).
  - The load then advances to MEM, and forwarding supplies the value.
- Transitions:
  - RUN→WAIT on `mw`.
  - WAIT→RUN on `mem_ack` (the pipeline advances that cycle; a pending `ex_br_taken` redirects in that same cycle).
  - WAIT→ERR when `wait_cnt` reaches `WAIT_LIMIT` with `mem_ack`=0.
  - ERR is left only by reset.
- ERR: every hold is 1, `memwb_flush`=1, `redirect`=0, `wait_err`=1.
- `wait_cnt` (8+ bits, sized to hold `WAIT_LIMIT`):
  - increments each cycle in WAIT while `mem_ack`=0;
  - clears when leaving WAIT.
- `stall_cnt` increments on every cycle with `pc_hold`=1, including ERR, and wraps 0xFFFFFFFF→0.
- Simultaneous `mem_req & mem_ack` in RUN: no stall, the state stays RUN.

## Timing

- Hazard controls have zero latency: they are valid in the same cycle as their inputs and take effect at the next `cpu_clk` edge.
- A load-use stall lasts exactly 1 cycle per occurrence. A back-to-back dependent load pair produces 1 bubble each.
- A RAM access acked N cycles after request produces N held cycles. An ack in the request cycle produces 0.
- Redirect costs 2 squashed instructions.
- Reset mid-WAIT: the next cycle is RUN with counters cleared; the outstanding `mem_ack` is ignored.

## Test plan

- Load-use: load `r5` in EX, ID reads `rR1`=5 with `re1`=1. Required: 1 cycle of `pc_hold`/`ifid_hold`/`idex_flush`, then no hold; `stall_cnt`=1. Repeat with `ex_wR`=0 → no stall.
- Branch: `ex_br_taken`=1, target 0x1C000040. Required: `redirect`=1, `redirect_pc`=0x1C000040, `ifid_flush`=`idex_flush`=1, no holds.
- RAM wait: `mem_req` with `mem_ack` 3 cycles later. Required: 3 cycles of all holds plus `memwb_flush`, state RUN on the ack cycle, `stall_cnt`=3.
- Branch during wait: `ex_br_taken`=1 throughout a 2-cycle wait. Required: `redirect`=0 while waiting, and `redirect`=1 exactly on the `mem_ack` cycle.
- Watchdog: `WAIT_LIMIT`=4, `mem_ack` never arrives. Required: `wait_err` rises after 4 wait cycles and holds stay 1; `cpu_rst` pulse → RUN, `wait_err`=0, `stall_cnt`=0.
- Wrap and reset: preload `stall_cnt` near 0xFFFFFFFF via sustained ERR. Required: wraps to 0. Assert `cpu_rst` mid-load-use: all flushes 1 and holds 0 during reset.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use bubbles, EX redirects, RAM-wait holds, wait watchdog and stall counter.
// Controls are combinational (zero latency); a RAM wait holds the whole front end and dominates redirects.
module pipe_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        id_valid,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  id_rR1,
  input  logic [4:0]  id_rR2,
  input  logic        ex_valid,
  input  logic        ex_rf_we,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_wR,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_hold,
  output logic        idex_flush,
  output logic        exmem_hold,
  output logic        memwb_flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wait_err,
  output logic [31:0] stall_cnt
);

  localparam int unsigned WCW = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]    stall_cnt_q;
  logic           wait_err_q;

  logic lu, mw, stall;

  assign lu = ex_valid & ex_rf_we & ex_is_load & (ex_wR != 5'd0) & id_valid &
              ((id_re1 & (id_rR1 == ex_wR)) | (id_re2 & (id_rR2 == ex_wR)));
  assign mw = mem_req & ~mem_ack;

  // Once in WAIT only the ack releases the pipe; ERR freezes it until reset.
  assign stall = (state_q == S_ERR) | ((state_q == S_WAIT) ? ~mem_ack : mw);

  assign redirect_pc = ex_br_target;
  assign wait_err    = wait_err_q;
  assign stall_cnt   = stall_cnt_q;

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    memwb_flush = 1'b0;
    redirect    = 1'b0;
    if (cpu_rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (stall) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_br_taken) begin
      redirect    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mw) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(WAIT_LIMIT - 1)) begin
          state_d    = S_ERR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= 32'd0;
      wait_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wait_err_q <= (state_d == S_ERR);
      if (pc_hold)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule
